// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bridge FSM encoding, full-word select and the
// read data returned for an aborted access (also used by the default slave).
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    localparam logic [3:0]  WB_SEL_ALL   = 4'hF;
    localparam logic [31:0] WB_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_cpu_bridge.sv
// Core valid/ready memory port to single Wishbone classic cycles, with a
// bounded ack timeout so a dead slave cannot stall the core.
module wb_cpu_bridge
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = WB_ERR_RDATA
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_bus_err,
    output logic [31:0] o_err_adr,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat
);

    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    function automatic logic [TW-1:0] timer_sat_inc(input logic [TW-1:0] t);
        return (t == T_MAX) ? t : t + TW'(1);
    endfunction

    wb_state_e     state;
    logic [TW-1:0] timer;
    logic [31:0]   req_adr;
    logic          err_q;

    assign o_wb_stb = o_wb_cyc;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            req_adr     <= '0;
            err_q       <= 1'b0;
            o_mem_ready <= 1'b0;
            o_mem_rdata <= '0;
            o_bus_err   <= 1'b0;
            o_err_adr   <= '0;
            o_wb_adr    <= '0;
            o_wb_dat    <= '0;
            o_wb_sel    <= '0;
            o_wb_we     <= 1'b0;
            o_wb_cyc    <= 1'b0;
        end else begin
            o_mem_ready <= 1'b0;
            o_bus_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // While ready is showing, valid still belongs to the request just completed.
                    if (i_mem_valid && !o_mem_ready) begin
                        req_adr  <= i_mem_addr;
                        o_wb_adr <= {i_mem_addr[31:2], 2'b00};
                        o_wb_dat <= i_mem_wdata;
                        o_wb_sel <= (|i_mem_wstrb) ? i_mem_wstrb : WB_SEL_ALL;
                        o_wb_we  <= |i_mem_wstrb;
                        o_wb_cyc <= 1'b1;
                        timer    <= '0;
                        err_q    <= 1'b0;
                        state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        if (!o_wb_we) begin
                            o_mem_rdata <= i_wb_dat;
                        end
                        state <= ST_DONE;
                    end else begin
                        timer <= timer_sat_inc(timer);
                        // Ack has priority: the timeout only fires on an ack-less cycle.
                        if (timer == T_LAST) begin
                            o_wb_cyc  <= 1'b0;
                            if (!o_wb_we) begin
                                o_mem_rdata <= ERR_RDATA;
                            end
                            o_err_adr <= req_adr;
                            err_q     <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    o_mem_ready <= 1'b1;
                    o_bus_err   <= err_q;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cpu_bridge.sv
// Scoreboard bench for wb_cpu_bridge: directed core requests against a
// latency-configurable slave model; bus and response monitors pop expectations.
module tb_wb_cpu_bridge;

    logic        clk;
    logic        i_wb_rst_n;
    logic        i_mem_valid;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [3:0]  i_mem_wstrb;
    logic        o_mem_ready;
    logic [31:0] o_mem_rdata;
    logic        o_bus_err;
    logic [31:0] o_err_adr;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        i_wb_ack;
    logic [31:0] i_wb_dat;

    wb_cpu_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (i_wb_rst_n),
        .i_mem_valid(i_mem_valid),
        .i_mem_addr (i_mem_addr),
        .i_mem_wdata(i_mem_wdata),
        .i_mem_wstrb(i_mem_wstrb),
        .o_mem_ready(o_mem_ready),
        .o_mem_rdata(o_mem_rdata),
        .o_bus_err  (o_bus_err),
        .o_err_adr  (o_err_adr),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .i_wb_ack   (i_wb_ack),
        .i_wb_dat   (i_wb_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          len;
    } wb_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] err_adr;
    } rsp_exp_t;

    wb_exp_t  wb_q[$];
    rsp_exp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int n_req = 0;
    int wb_starts = 0;
    int rdy_cnt = 0;
    int slv_lat = 99;
    int slv_cnt = 0;
    logic [31:0] slv_dat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slave: ack after slv_lat+1 negedges of stb (slv_lat=99 means never).
    initial begin
        i_wb_ack = 1'b0;
        i_wb_dat = '0;
        forever begin
            @(negedge clk);
            if (i_wb_ack) begin
                i_wb_ack = 1'b0;
                slv_cnt  = 0;
            end else if (o_wb_cyc && o_wb_stb) begin
                slv_cnt++;
                if (slv_cnt == slv_lat + 1) begin
                    i_wb_ack = 1'b1;
                    i_wb_dat = slv_dat;
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    // Monitors: Wishbone cycle contents/length and core-side responses.
    wb_exp_t cur_wb;
    logic    prev_cyc = 1'b0;
    int      stb_len = 0;
    always @(negedge clk) begin
        if (o_wb_cyc && !prev_cyc) begin
            wb_starts++;
            stb_len = 1;
            if (wb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_wb_cycle: adr %h", o_wb_adr);
                cur_wb.len = -1;
            end else begin
                cur_wb = wb_q.pop_front();
                chk("wb_adr", o_wb_adr, cur_wb.adr);
                chk("wb_sel", {28'd0, o_wb_sel}, {28'd0, cur_wb.sel});
                chk("wb_we", {31'd0, o_wb_we}, {31'd0, cur_wb.we});
                chk("wb_dat", o_wb_dat, cur_wb.dat);
                chk("wb_stb_eq_cyc", {31'd0, o_wb_stb}, 32'd1);
            end
        end else if (o_wb_cyc) begin
            stb_len++;
        end else if (prev_cyc && cur_wb.len >= 0) begin
            chk("wb_stb_len", 32'(stb_len), 32'(cur_wb.len));
        end
        prev_cyc = o_wb_cyc;

        if (o_mem_ready) begin
            rsp_exp_t r;
            rdy_cnt++;
            if (rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: at cycle %0d", cyc_cnt);
            end else begin
                r = rsp_q.pop_front();
                chk("ready_cycle", 32'(cyc_cnt), 32'(r.cyc));
                chk("mem_rdata", o_mem_rdata, r.rdata);
                chk("bus_err", {31'd0, o_bus_err}, {31'd0, r.err});
                chk("err_adr", o_err_adr, r.err_adr);
            end
        end else if (o_bus_err) begin
            checks++; errors++;
            $display("FAIL bus_err_without_ready: at cycle %0d", cyc_cnt);
        end
    end

    // Issue one request; e0 is the next rising edge. k = edges from e0 to ready.
    task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input int lat, input logic [31:0] sdat,
                       input logic [31:0] e_adr, input logic [3:0] e_sel, input logic e_we,
                       input int e_len, input int k, input logic [31:0] e_rd,
                       input logic e_err, input logic [31:0] e_eadr);
        wb_exp_t  w;
        rsp_exp_t r;
        bit       got = 0;
        slv_lat = lat;
        slv_dat = sdat;
        i_mem_addr  = a;
        i_mem_wdata = wd;
        i_mem_wstrb = st;
        i_mem_valid = 1'b1;
        w.adr = e_adr; w.dat = wd; w.sel = e_sel; w.we = e_we; w.len = e_len;
        r.cyc = cyc_cnt + 1 + k; r.rdata = e_rd; r.err = e_err; r.err_adr = e_eadr;
        wb_q.push_back(w);
        rsp_q.push_back(r);
        n_req++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_mem_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ready_timeout: addr %h got no ready, required one", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_mem_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_wb_rst_n  = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_addr  = '0;
        i_mem_wdata = '0;
        i_mem_wstrb = '0;
        #12;
        chk("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("rst_stb", {31'd0, o_wb_stb}, 32'd0);
        chk("rst_we", {31'd0, o_wb_we}, 32'd0);
        chk("rst_ready", {31'd0, o_mem_ready}, 32'd0);
        chk("rst_bus_err", {31'd0, o_bus_err}, 32'd0);
        chk("rst_wb_adr", o_wb_adr, 32'd0);
        chk("rst_wb_dat", o_wb_dat, 32'd0);
        chk("rst_rdata", o_mem_rdata, 32'd0);
        chk("rst_err_adr", o_err_adr, 32'd0);
        chk("rst_sel", {28'd0, o_wb_sel}, 32'd0);
        @(negedge clk);
        i_wb_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAM-like read, write with partial strobes, timeouts, ack on timeout edge
        req(32'h0000_0040, 32'h0, 4'b0000, 2, 32'h1234_5678,
            32'h0000_0040, 4'hF, 1'b0, 3, 4, 32'h1234_5678, 1'b0, 32'h0);
        idle(2);
        req(32'h0000_0103, 32'hAABB_CCDD, 4'b0110, 1, 32'hFFFF_FFFF,
            32'h0000_0100, 4'b0110, 1'b1, 2, 3, 32'h1234_5678, 1'b0, 32'h0);
        idle(2);
        req(32'h8000_0000, 32'h0, 4'b0000, 99, 32'h0,
            32'h8000_0000, 4'hF, 1'b0, 4, 5, 32'hDEAD_BEEF, 1'b1, 32'h8000_0000);
        idle(2);
        req(32'h0000_0044, 32'h0, 4'b0000, 3, 32'h0BAD_F00D,
            32'h0000_0044, 4'hF, 1'b0, 4, 5, 32'h0BAD_F00D, 1'b0, 32'h8000_0000);
        idle(2);

        // Valid held through completion, next request presented right after ready
        req(32'h0000_0200, 32'h1122_3344, 4'b1111, 1, 32'hFFFF_FFFF,
            32'h0000_0200, 4'hF, 1'b1, 2, 3, 32'h0BAD_F00D, 1'b0, 32'h8000_0000);
        req(32'h0000_0204, 32'h0, 4'b0000, 2, 32'hCAFE_0001,
            32'h0000_0204, 4'hF, 1'b0, 3, 4, 32'hCAFE_0001, 1'b0, 32'h8000_0000);
        idle(2);

        // Write timeout: rdata holds, error still reported
        req(32'h0000_0300, 32'h5A5A_5A5A, 4'b1000, 99, 32'h0,
            32'h0000_0300, 4'b1000, 1'b1, 4, 5, 32'hCAFE_0001, 1'b1, 32'h0000_0300);
        idle(2);

        // Asynchronous reset in the middle of a bus cycle
        begin
            wb_exp_t w;
            slv_lat = 99;
            i_mem_addr  = 32'h0000_0500;
            i_mem_wdata = 32'h0;
            i_mem_wstrb = 4'b0000;
            i_mem_valid = 1'b1;
            w.adr = 32'h0000_0500; w.dat = 32'h0; w.sel = 4'hF; w.we = 1'b0; w.len = 2;
            wb_q.push_back(w);
            n_req++;
            @(posedge clk);
            @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            #2;
            chk("pre_rst_cyc", {31'd0, o_wb_cyc}, 32'd1);
            i_wb_rst_n  = 1'b0;
            i_mem_valid = 1'b0;
            #1;
            chk("async_rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
            chk("async_rst_stb", {31'd0, o_wb_stb}, 32'd0);
            chk("async_rst_ready", {31'd0, o_mem_ready}, 32'd0);
            chk("async_rst_err_adr", o_err_adr, 32'd0);
            chk("async_rst_rdata", o_mem_rdata, 32'd0);
            @(negedge clk);
            i_wb_rst_n = 1'b1;
            idle(6);
        end

        // FSM back in IDLE: a normal read completes with standard latency
        req(32'h0000_0010, 32'h0, 4'b0000, 2, 32'h5555_AAAA,
            32'h0000_0010, 4'hF, 1'b0, 3, 4, 32'h5555_AAAA, 1'b0, 32'h0);
        idle(4);

        chk("wb_cycle_count", 32'(wb_starts), 32'(n_req));
        chk("ready_count", 32'(rdy_cnt), 32'(n_req - 1));
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
